// File: rtl/road_fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : road_fighter_pkg
// Purpose  : Shared types and constants for the road-fighter object pipeline:
//            the packed object-table entry, its field indices, image IDs, the
//            player FSM encoding and the road bounds used by every mover.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package road_fighter_pkg;

  // One object-table entry: {img_id, x, y, width, height}, 11 bits each.
  typedef logic [0:4][0:10] obj_state_t;

  localparam int F_IMG = 0;
  localparam int F_X   = 1;
  localparam int F_Y   = 2;
  localparam int F_W   = 3;
  localparam int F_H   = 4;

  localparam logic [10:0] IMG_CAR   = 11'd0;
  localparam logic [10:0] IMG_CRASH = 11'd1;
  localparam logic [10:0] IMG_ROAD  = 11'd31;

  typedef enum logic [1:0] {
    DRIVE   = 2'd0,
    CRASH   = 2'd1,
    RECOVER = 2'd2
  } player_state_t;

  // Road bounds shared with the object table and the background mover.
  localparam int ROAD_LEFT_X  = 106;
  localparam int ROAD_RIGHT_X = 424;

  // Saturate a 12-bit position into [lo, hi].
  function automatic logic [11:0] clamp_x(input logic [11:0] x,
                                          input logic [11:0] lo,
                                          input logic [11:0] hi);
    logic [11:0] res;
    res = x;
    if (x < lo) res = lo;
    else if (x > hi) res = hi;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : scroll_accumulator
// Purpose  : Converts a speed in 1/16 px/frame into whole-pixel road scroll
//            steps, carrying the fractional remainder from frame to frame.
// Ports    : clk, resetN      - clock, async active-low reset
//            frame_start      - one-cycle frame tick
//            speed [5:0]      - speed that applies to this frame
//            scroll_step[3:0] - whole pixels the road advances this frame
// Revision : 1.0 - initial release
// ============================================================================
module scroll_accumulator (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_start,
  input  logic [5:0] speed,
  output logic [3:0] scroll_step
);

  logic [3:0] r_acc;
  logic [3:0] r_step;
  logic [6:0] w_sum;

  // Remainder (<16) plus speed (<64) always fits in 7 bits.
  assign w_sum = {3'b000, r_acc} + {1'b0, speed};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc  <= 4'd0;
      r_step <= 4'd0;
    end else if (frame_start) begin
      r_acc  <= w_sum[3:0];
      r_step <= {1'b0, w_sum[6:4]};
    end
  end

  assign scroll_step = r_step;

endmodule
`default_nettype wire

// File: rtl/player_car_controller.sv
`default_nettype none
// ============================================================================
// Module   : player_car_controller
// Purpose  : Once-per-frame update of the player car: speed, steering,
//            crash/recover sequence, sprite, and the road scroll step.
//            Optional fuel model is compiled in with `define PLAYER_FUEL_EN.
// Ports    : clk, resetN            - clock, async active-low reset
//            frame_start            - one-cycle pulse per video frame
//            plus/minus_is_pressed  - accelerate / brake held
//            left/right_pressed     - steering held
//            collision              - one-cycle overlap pulse (latched)
//            fuel_pickup, fuel[7:0] - only with PLAYER_FUEL_EN
//            new_player_state       - {img_id, x, y, width, height}
//            speed[5:0]             - current speed (1/16 px/frame)
//            scroll_step[3:0]       - road advance this frame
//            crashed                - high in CRASH or RECOVER
// Revision : 1.0 - initial release
// ============================================================================
module player_car_controller
  import road_fighter_pkg::*;
#(
  parameter int START_X      = 300,
  parameter int Y_POS        = 7,
  parameter int CAR_W        = 16,
  parameter int CAR_H        = 32,
  parameter int ROAD_LEFT    = ROAD_LEFT_X,
  parameter int ROAD_RIGHT   = ROAD_RIGHT_X,
  parameter int MAX_SPEED    = 48,
  parameter int STEER_STEP   = 2,
  parameter int DECAY_FRAMES = 8,
  parameter int CRASH_FRAMES = 60,
  parameter int CRASH_IMG    = 1
)(
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_start,
  input  logic       plus_is_pressed,
  input  logic       minus_is_pressed,
  input  logic       left_pressed,
  input  logic       right_pressed,
  input  logic       collision,
`ifdef PLAYER_FUEL_EN
  input  logic       fuel_pickup,
  output logic [7:0] fuel,
`endif
  output obj_state_t new_player_state,
  output logic [5:0] speed,
  output logic [3:0] scroll_step,
  output logic       crashed
);

  localparam int c_decay_w = $clog2(DECAY_FRAMES + 1);
  localparam int c_crash_w = $clog2(CRASH_FRAMES + 1);

  localparam logic [11:0]          c_x_min      = 12'(ROAD_LEFT);
  localparam logic [11:0]          c_x_max      = 12'(ROAD_RIGHT - CAR_W);
  localparam logic [11:0]          c_x_start    = 12'(START_X);
  localparam logic [11:0]          c_step       = 12'(STEER_STEP);
  localparam logic [5:0]           c_speed_max  = 6'(MAX_SPEED);
  localparam logic [c_decay_w-1:0] c_decay_last = c_decay_w'(DECAY_FRAMES - 1);
  localparam logic [c_crash_w-1:0] c_crash_last = c_crash_w'(CRASH_FRAMES - 1);

  player_state_t        r_state, w_state_nxt;
  logic [10:0]          r_x, w_x_nxt;
  logic [10:0]          r_img, w_img_nxt;
  logic [5:0]           r_speed, w_speed_nxt;
  logic [c_decay_w-1:0] r_decay, w_decay_nxt;
  logic [c_crash_w-1:0] r_crash_cnt, w_crash_nxt;
  logic                 r_coll;
  logic                 w_coll_hit;
  logic                 w_plus;
  logic [11:0]          w_x12;
  logic [11:0]          w_x_move;

  // A pulse coinciding with frame_start counts for this frame.
  assign w_coll_hit = r_coll | collision;
  assign w_x12      = {1'b0, r_x};

`ifdef PLAYER_FUEL_EN
  logic [7:0] r_fuel;
  logic [3:0] r_fuel_div;
  logic       r_pickup;

  // An empty tank disables the accelerator only; braking still works.
  assign w_plus = plus_is_pressed & (r_fuel != 8'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fuel     <= 8'd255;
      r_fuel_div <= 4'd0;
      r_pickup   <= 1'b0;
    end else begin
      if (fuel_pickup) r_pickup <= 1'b1;
      if (frame_start) begin
        r_pickup <= 1'b0;
        if (r_speed != 6'd0) r_fuel_div <= r_fuel_div + 4'd1;
        if (r_pickup | fuel_pickup)
          r_fuel <= 8'd255;
        else if (r_speed != 6'd0 && r_fuel_div == 4'hF && r_fuel != 8'd0)
          r_fuel <= r_fuel - 8'd1;
      end
    end
  end

  assign fuel = r_fuel;
`else
  assign w_plus = plus_is_pressed;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_img_nxt   = r_img;
    w_speed_nxt = r_speed;
    w_decay_nxt = r_decay;
    w_crash_nxt = r_crash_cnt;
    w_x_move    = w_x12;

    case (r_state)
      DRIVE: begin
        if (w_coll_hit && r_speed != 6'd0) begin
          w_state_nxt = CRASH;
          w_speed_nxt = 6'd0;
          w_img_nxt   = 11'(CRASH_IMG);
          w_decay_nxt = '0;
          w_crash_nxt = '0;
        end else begin
          if (w_plus && !minus_is_pressed) begin
            w_decay_nxt = '0;
            w_speed_nxt = (r_speed >= c_speed_max) ? c_speed_max : r_speed + 6'd1;
          end else if (minus_is_pressed && !w_plus) begin
            w_decay_nxt = '0;
            w_speed_nxt = (r_speed >= 6'd2) ? r_speed - 6'd2 : 6'd0;
          end else if (r_decay == c_decay_last) begin
            w_decay_nxt = '0;
            if (r_speed != 6'd0) w_speed_nxt = r_speed - 6'd1;
          end else begin
            w_decay_nxt = r_decay + c_decay_w'(1);
          end

          // Steering uses the speed the car had entering this frame.
          if (r_speed != 6'd0) begin
            if (left_pressed && !right_pressed)      w_x_move = w_x12 - c_step;
            else if (right_pressed && !left_pressed) w_x_move = w_x12 + c_step;
          end
          w_x_move = clamp_x(w_x_move, c_x_min, c_x_max);
        end
      end

      CRASH: begin
        w_speed_nxt = 6'd0;
        if (r_crash_cnt == c_crash_last) begin
          w_state_nxt = RECOVER;
          w_img_nxt   = IMG_CAR;
          w_crash_nxt = '0;
        end else begin
          w_crash_nxt = r_crash_cnt + c_crash_w'(1);
        end
      end

      RECOVER: begin
        w_speed_nxt = 6'd0;
        // Step toward the start lane; the last step lands exactly on it.
        if (w_x12 == c_x_start)
          w_state_nxt = DRIVE;
        else if (w_x12 > c_x_start)
          w_x_move = (w_x12 - c_x_start > c_step) ? w_x12 - c_step : c_x_start;
        else
          w_x_move = (c_x_start - w_x12 > c_step) ? w_x12 + c_step : c_x_start;
      end

      default: w_state_nxt = DRIVE;
    endcase

    w_x_nxt = w_x_move[10:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= DRIVE;
      r_x         <= 11'(START_X);
      r_img       <= IMG_CAR;
      r_speed     <= 6'd0;
      r_decay     <= '0;
      r_crash_cnt <= '0;
      r_coll      <= 1'b0;
    end else begin
      if (collision) r_coll <= 1'b1;
      if (frame_start) begin
        r_coll      <= 1'b0;
        r_state     <= w_state_nxt;
        r_x         <= w_x_nxt;
        r_img       <= w_img_nxt;
        r_speed     <= w_speed_nxt;
        r_decay     <= w_decay_nxt;
        r_crash_cnt <= w_crash_nxt;
      end
    end
  end

  scroll_accumulator u_scroll (
    .clk         (clk),
    .resetN      (resetN),
    .frame_start (frame_start),
    .speed       (w_speed_nxt),
    .scroll_step (scroll_step)
  );

  assign new_player_state[F_IMG] = r_img;
  assign new_player_state[F_X]   = r_x;
  assign new_player_state[F_Y]   = 11'(Y_POS);
  assign new_player_state[F_W]   = 11'(CAR_W);
  assign new_player_state[F_H]   = 11'(CAR_H);
  assign speed                   = r_speed;
  assign crashed                 = (r_state != DRIVE);

endmodule
`default_nettype wire

// File: tb/tb_player_car_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_car_controller
// Purpose  : Self-checking bench for player_car_controller. Directed phases
//            followed by random driving, all compared against a frame-level
//            behavioural model of the car.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_car_controller;
  import road_fighter_pkg::*;

  logic       clk              = 1'b0;
  logic       resetN           = 1'b0;
  logic       frame_start      = 1'b0;
  logic       plus_is_pressed  = 1'b0;
  logic       minus_is_pressed = 1'b0;
  logic       left_pressed     = 1'b0;
  logic       right_pressed    = 1'b0;
  logic       collision        = 1'b0;
  obj_state_t new_player_state;
  logic [5:0] speed;
  logic [3:0] scroll_step;
  logic       crashed;
`ifdef PLAYER_FUEL_EN
  logic       fuel_pickup = 1'b0;
  logic [7:0] fuel;
`endif

  always #5 clk = ~clk;

  player_car_controller dut (
    .clk              (clk),
    .resetN           (resetN),
    .frame_start      (frame_start),
    .plus_is_pressed  (plus_is_pressed),
    .minus_is_pressed (minus_is_pressed),
    .left_pressed     (left_pressed),
    .right_pressed    (right_pressed),
    .collision        (collision),
`ifdef PLAYER_FUEL_EN
    .fuel_pickup      (fuel_pickup),
    .fuel             (fuel),
`endif
    .new_player_state (new_player_state),
    .speed            (speed),
    .scroll_step      (scroll_step),
    .crashed          (crashed)
  );

  int total = 0;
  int bad   = 0;

  // Frame-level reference model.
  int m_x, m_speed, m_decay, m_acc, m_step, m_img, m_crash_left;
  bit m_recover;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 300; m_speed = 0; m_decay = 0; m_acc = 0; m_step = 0;
    m_img = 0; m_crash_left = 0; m_recover = 0;
  endtask

  task automatic model_frame(input bit p, input bit m, input bit l, input bit r, input bit coll);
    int old_speed;
    old_speed = m_speed;
    if (m_crash_left > 0) begin
      m_crash_left--;
      if (m_crash_left == 0) begin
        m_recover = 1;
        m_img = 0;
      end
    end else if (m_recover) begin
      if (m_x == 300) m_recover = 0;
      else if (m_x > 300) m_x = (m_x - 300 > 2) ? m_x - 2 : 300;
      else m_x = (300 - m_x > 2) ? m_x + 2 : 300;
    end else if (coll && old_speed > 0) begin
      m_crash_left = 60;   // crash sprite shown for 60 frames incl. this one
      m_speed = 0;
      m_img = 1;
      m_decay = 0;
    end else begin
      if (p && !m) begin
        m_speed = (m_speed + 1 > 48) ? 48 : m_speed + 1;
        m_decay = 0;
      end else if (m && !p) begin
        m_speed = (m_speed - 2 < 0) ? 0 : m_speed - 2;
        m_decay = 0;
      end else begin
        m_decay++;
        if (m_decay == 8) begin
          m_decay = 0;
          if (m_speed > 0) m_speed--;
        end
      end
      if (old_speed > 0) begin
        if (l && !r) m_x -= 2;
        else if (r && !l) m_x += 2;
        if (m_x < 106) m_x = 106;
        if (m_x > 408) m_x = 408;
      end
    end
    m_acc  = m_acc + m_speed;
    m_step = m_acc / 16;
    m_acc  = m_acc % 16;
  endtask

  task automatic check_all();
    chk("speed",   speed, m_speed);
    chk("scroll",  scroll_step, m_step);
    chk("crashed", crashed, (m_crash_left > 0 || m_recover) ? 1 : 0);
    chk("img",     new_player_state[F_IMG], m_img);
    chk("x",       new_player_state[F_X], m_x);
    chk("y",       new_player_state[F_Y], 7);
    chk("width",   new_player_state[F_W], 16);
    chk("height",  new_player_state[F_H], 32);
  endtask

  // One frame: buttons set, optional mid-frame collision, frame tick, check.
  task automatic run_frame(input bit p, input bit m, input bit l, input bit r, input bit coll);
    plus_is_pressed  = p;
    minus_is_pressed = m;
    left_pressed     = l;
    right_pressed    = r;
    @(negedge clk);
    if (coll) begin
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    model_frame(p, m, l, r, coll);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
`ifdef PLAYER_FUEL_EN
    chk("fuel_reset", fuel, 255);
`endif
    resetN = 1'b1;
    @(negedge clk);
    check_all();

    // Idle frames.
    repeat (10) run_frame(0, 0, 0, 0, 0);

    // Acceleration to the ceiling.
    repeat (60) run_frame(1, 0, 0, 0, 0);
    chk("speed_saturated", speed, 48);
    chk("scroll_at_max", scroll_step, 3);

    // Brake to 16, then steer into both road edges.
    repeat (16) run_frame(0, 1, 0, 0, 0);
    chk("speed_16", speed, 16);
    repeat (200) run_frame(0, 0, 1, 0, 0);
    chk("x_left_clamp", new_player_state[F_X], 106);
    repeat (200) run_frame(1, 0, 0, 1, 0);
    chk("x_right_clamp", new_player_state[F_X], 408);
    repeat (10) run_frame(1, 0, 1, 1, 0);
    chk("x_both_hold", new_player_state[F_X], 408);

    // Coasting decay from speed 5, with no buttons and with both pedals.
    repeat (30) run_frame(0, 1, 0, 0, 0);
    repeat (5) run_frame(1, 0, 0, 0, 0);
    chk("speed_5", speed, 5);
    for (int i = 0; i < 40; i++) begin
      run_frame(0, 0, 0, 0, 0);
      if (i == 38) chk("coast_39", speed, 1);
    end
    chk("coast_40", speed, 0);
    repeat (5) run_frame(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_frame(1, 1, 0, 0, 0);
      if (i == 38) chk("both_39", speed, 1);
    end
    chk("both_40", speed, 0);

    // Set up speed 20 at x=310, then crash.
    repeat (50) run_frame(1, 0, 1, 0, 0);
    repeat (14) run_frame(0, 1, 0, 0, 0);
    chk("pre_crash_x", new_player_state[F_X], 310);
    chk("pre_crash_speed", speed, 20);
    run_frame(0, 0, 0, 0, 1);
    chk("crash_img", new_player_state[F_IMG], 1);
    chk("crash_speed", speed, 0);
    chk("crash_flag", crashed, 1);
    repeat (9) run_frame(1, 0, 1, 0, 0);
    run_frame(1, 0, 0, 1, 1);         // collision during CRASH is discarded
    repeat (49) run_frame(0, 0, 0, 0, 0);
    chk("crash_last_img", new_player_state[F_IMG], 1);
    run_frame(0, 0, 0, 0, 0);
    chk("recover_img", new_player_state[F_IMG], 0);
    chk("recover_crashed", crashed, 1);
    for (int i = 0; i < 5; i++) begin
      run_frame(1, 0, 1, 0, 0);
      chk("recover_x", new_player_state[F_X], 308 - 2 * i);
    end
    run_frame(0, 0, 0, 0, 0);
    chk("back_to_drive", crashed, 0);

    // Second crash, asynchronous reset in the middle of RECOVER.
    repeat (5) run_frame(1, 0, 0, 1, 0);
    run_frame(0, 0, 0, 0, 1);
    guard = 0;
    while (!(m_recover && m_x == 304) && guard < 100) begin
      run_frame(0, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_recover_304", guard < 100, 1);
    #3;
    resetN = 1'b0;
    #1;
    model_reset();
    check_all();
`ifdef PLAYER_FUEL_EN
    chk("fuel_after_reset", fuel, 255);
`endif
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    run_frame(0, 0, 0, 0, 0);

    // Random driving.
    for (int i = 0; i < 300; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_car_controller.md
Name: player_car_controller

Overview:
- Upstream producer of the player entry in the object table. Consumes the `frame_start` tick, driver buttons and a collision pulse.
- Once per frame it updates the player car's speed, lateral position and sprite. It emits the packed 5-field state word (img_id, x, y, width, height) for the object table.
- It also emits a per-frame road scroll step for the background/computer-car movers.

Parameters:
- START_X, 300, reset and recovery x position (pixels)
- Y_POS, 7, fixed player y position
- CAR_W, 16, sprite width
- CAR_H, 32, sprite height
- ROAD_LEFT, 106, leftmost legal x
- ROAD_RIGHT, 424, rightmost legal x + CAR_W
- MAX_SPEED, 48, speed ceiling (units of 1/16 px/frame)
- STEER_STEP, 2, lateral pixels per frame
- DECAY_FRAMES, 8, coasting frames per 1-unit speed decay
- CRASH_FRAMES, 60, frames spent in CRASH
- CRASH_IMG, 1, img_id shown while crashed

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- frame_start  in  1  one-cycle pulse per video frame
- plus_is_pressed  in  1  accelerate held
- minus_is_pressed  in  1  brake held
- left_pressed  in  1  steer left held
- right_pressed  in  1  steer right held
- collision  in  1  one-cycle pulse, player overlapped another object
- new_player_state  out  [0:4][0:10]  {img_id, x, y, width, height}
- speed  out  6  current speed
- scroll_step  out  4  whole pixels the road advances this frame
- crashed  out  1  high in CRASH or RECOVER

Behaviour:
- Reset is asynchronous, active-low on resetN; clock is clk.
- Reset values:
  - new_player_state = {0, START_X, Y_POS, CAR_W, CAR_H}
  - speed = 0, scroll_step = 0, crashed = 0
  - fractional accumulator = 0, decay counter = 0, crash counter = 0
  - state = DRIVE
- All updates occur on the clk edge where `frame_start` = 1. Outputs change exactly 1 clk after that edge and are held for the rest of the frame.
- `collision` is latched at any cycle into a sticky flag. The flag is consumed and cleared at the next `frame_start`. A collision arriving in the same cycle as `frame_start` counts for that frame.
- FSM states:
  - DRIVE: speed and steering active.
  - CRASH: speed forced 0, img_id = CRASH_IMG, buttons ignored.
  - RECOVER: img_id 0, x moves STEER_STEP toward START_X per frame (final step clamped so x never overshoots), buttons ignored.
- Transitions:
  - DRIVE→CRASH: latched collision and speed > 0. Collision at speed 0 is ignored.
  - CRASH→RECOVER: after CRASH_FRAMES frames.
  - RECOVER→DRIVE: on the frame x == START_X.
  - Collisions in CRASH/RECOVER are discarded.
- Speed rules in DRIVE:
  - plus only: +1, saturating at MAX_SPEED.
  - minus only: −2, saturating at 0.
  - both or neither: coast. Decay counter increments; at DECAY_FRAMES it wraps to 0 and speed decrements by 1 (floor 0).
  - Any plus/minus press clears the decay counter.
- Steering in DRIVE:
  - Applies only if speed > 0 (old speed value).
  - left only: x −= STEER_STEP; right only: x += STEER_STEP; both: no move.
  - Clamp x to [ROAD_LEFT, ROAD_RIGHT−CAR_W]. No wrap-around; arithmetic is done in 12 bits before clamping.
- Scroll:
  - acc5 = {1'b0, acc} + new speed.
  - scroll_step = acc5 >> 4 (0..3 for MAX_SPEED 48); acc = acc5[3:0] is retained.
  - In CRASH, speed is 0, so the accumulator holds its value.
- Fields y, width and height are constant. All fields are 11 bits, zero-extended.

Optional Feature:
- Macro: PLAYER_FUEL_EN.
- When defined:
  - Adds output `fuel` (8 bits, reset 255) and input `fuel_pickup` (1-cycle pulse, latched like `collision`).
  - `fuel` decrements by 1 every 16 frames while speed > 0, floor 0.
  - A pickup sets fuel to 255 at the next frame; pickup beats decrement.
  - With fuel == 0, plus is treated as not pressed.
- When undefined: no ports, no fuel logic; behaviour as above.

Decomposition:
- Package road_fighter_pkg:
  - typedef obj_state_t (logic [0:4][0:10])
  - field index constants F_IMG=0, F_X=1, F_Y=2, F_W=3, F_H=4
  - image ID constants IMG_CAR=0, IMG_CRASH=1, IMG_ROAD=31
  - FSM enum player_state_t {DRIVE, CRASH, RECOVER}
  - road bound constants shared with the object table and background mover
- One sub-module, `scroll_accumulator`: takes speed and frame_start; outputs scroll_step and holds the fractional remainder.

Test Plan:
- Reset, then 10 frames with no input → state {0,300,7,16,32}; speed 0; scroll_step 0 every frame.
- plus held 60 frames → speed 1,2,…,48, then stays 48. At speed 48 with acc 0: scroll_step = 3 each frame, acc stays 0.
- Speed 16, left held 200 frames → x decreases by 2/frame down to 106, then holds 106. Right held → x clamps at 408. Left+right together → x unchanged.
- Speed 5, no buttons, 40 frames → speed drops by 1 every 8th frame, reaching 0 at frame 40. plus and minus together behave the same as no buttons.
- Speed 20, x=310, `collision` pulsed mid-frame:
  - next frame: img_id 1, speed 0, crashed 1;
  - 60 frames later RECOVER with img_id 0, x steps 308…300;
  - then DRIVE, crashed 0.
  - A collision pulse during CRASH has no effect.
- Assert resetN mid-RECOVER at x=304 → outputs immediately return to reset values, state DRIVE. With PLAYER_FUEL_EN: fuel back to 255.
